// File: rtl/noc_pkg.sv
// Shared definitions for the mesh router input buffer: flit field layout,
// flit type encodings, port indices and the input-buffer FSM state type.
package noc_pkg;

  localparam logic [1:0] FLIT_HDR    = 2'b10;
  localparam logic [1:0] FLIT_BODY   = 2'b00;
  localparam logic [1:0] FLIT_TAIL   = 2'b01;
  localparam logic [1:0] FLIT_SINGLE = 2'b11;

  localparam int TYPE_MSB = 7;
  localparam int TYPE_LSB = 6;
  localparam int DX_MSB   = 3;
  localparam int DX_LSB   = 2;
  localparam int DY_MSB   = 1;
  localparam int DY_LSB   = 0;

  localparam int L = 1;
  localparam int E = 2;
  localparam int N = 3;
  localparam int W = 4;
  localparam int S = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DROP   = 2'd2
  } state_t;

endpackage

// File: rtl/noc_flit_fifo.sv
// Plain synchronous flit FIFO with asynchronous reset on pointers and count.
// Storage is not reset; occupancy alone defines which entries are valid.
module noc_flit_fifo
  import noc_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int FLIT_W = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [FLIT_W-1:0] push_data,
  input  logic              pop,
  output logic [FLIT_W-1:0] head,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Full/empty come from the registered count, so a push while full is
  // refused even when a pop happens in the same cycle.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/noc_input_buffer.sv
// Wormhole input buffer: FIFO + route latch + allocator request/drain FSM.
// Optional NOC_CREDIT_OUT_EN adds a credit_out pulse on every pop.
module noc_input_buffer
  import noc_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int FLIT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] flit_in,
  input  logic              flit_in_valid,
  output logic              buf_full,
  output logic [FLIT_W-1:0] hdr_out,
  input  logic [4:0]        route_in,
  output logic [4:0]        req_out,
  input  logic              grant_in,
  output logic [FLIT_W-1:0] flit_out,
  output logic              flit_out_valid,
  output logic              drop_pulse
`ifdef NOC_CREDIT_OUT_EN
  ,
  output logic              credit_out
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_t            state;
  state_t            state_d;
  logic [4:0]        route_reg;
  logic [4:0]        route_d;
  logic              pop;
  logic [FLIT_W-1:0] head;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              has_flit;
  logic [1:0]        head_type;
  logic              head_is_hdr;
  logic              head_ends_pkt;

  noc_flit_fifo #(
    .DEPTH  (DEPTH),
    .FLIT_W (FLIT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (flit_in_valid),
    .push_data (flit_in),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign has_flit      = (count != '0);
  assign head_type     = head[TYPE_MSB:TYPE_LSB];
  assign head_is_hdr   = (head_type == FLIT_HDR) || (head_type == FLIT_SINGLE);
  assign head_ends_pkt = (head_type == FLIT_TAIL) || (head_type == FLIT_SINGLE);

  assign buf_full = full;
  assign hdr_out  = empty ? '0 : head;
  assign flit_out = flit_out_valid ? head : '0;

`ifdef NOC_CREDIT_OUT_EN
  assign credit_out = pop;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      route_reg <= '0;
    end else begin
      state     <= state_d;
      route_reg <= route_d;
    end
  end

  always_comb begin
    state_d        = state;
    route_d        = route_reg;
    pop            = 1'b0;
    req_out        = '0;
    flit_out_valid = 1'b0;
    drop_pulse     = 1'b0;
    case (state)
      IDLE: begin
        if (has_flit) begin
          if (head_is_hdr) begin
            // A multi-hot route is not a decision yet; wait for route compute.
            if ($onehot(route_in)) begin
              route_d = route_in;
              state_d = ACTIVE;
            end else if (route_in == '0) begin
              pop        = 1'b1;
              drop_pulse = 1'b1;
              if (head_type == FLIT_HDR) state_d = DROP;
            end
          end else begin
            pop        = 1'b1;
            drop_pulse = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (has_flit) begin
          req_out = route_reg;
          if (grant_in) begin
            pop            = 1'b1;
            flit_out_valid = 1'b1;
            if (head_ends_pkt) begin
              route_d = '0;
              state_d = IDLE;
            end
          end
        end
      end
      DROP: begin
        if (has_flit) begin
          pop        = 1'b1;
          drop_pulse = 1'b1;
          if (head_type == FLIT_TAIL) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_noc_input_buffer.sv
// Directed bench for noc_input_buffer with a transfer scoreboard.
module tb_noc_input_buffer;
  import noc_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] flit_in;
  logic       flit_in_valid;
  logic       buf_full;
  logic [7:0] hdr_out;
  logic [4:0] route_in;
  logic [4:0] req_out;
  logic       grant_in;
  logic [7:0] flit_out;
  logic       flit_out_valid;
  logic       drop_pulse;
`ifdef NOC_CREDIT_OUT_EN
  logic       credit_out;
`endif

  int         checks   = 0;
  int         failures = 0;
  int         xfers    = 0;
  int         x0;
  logic [7:0] sb[$];
  logic [4:0] r_e;
  logic [4:0] r_l;

  noc_input_buffer #(.DEPTH(4), .FLIT_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .flit_in        (flit_in),
    .flit_in_valid  (flit_in_valid),
    .buf_full       (buf_full),
    .hdr_out        (hdr_out),
    .route_in       (route_in),
    .req_out        (req_out),
    .grant_in       (grant_in),
    .flit_out       (flit_out),
    .flit_out_valid (flit_out_valid),
    .drop_pulse     (drop_pulse)
`ifdef NOC_CREDIT_OUT_EN
    ,
    .credit_out     (credit_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] f);
    flit_in_valid = v;
    flit_in       = f;
  endtask

  // Every transfer must match the next flit queued when it was driven.
  always @(negedge clk) begin
    if (flit_out_valid === 1'b1) begin
      logic [7:0] e;
      xfers++;
      if (sb.size() > 0) e = sb.pop_front();
      else e = 'x;
      chk("sb_flit", {24'b0, flit_out}, {24'b0, e});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    r_e = 5'(1 << (E - 1));
    r_l = 5'(1 << (L - 1));
    rst = 1'b1; flit_in = '0; flit_in_valid = 1'b0; route_in = '0; grant_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_full", 32'(buf_full), 0);
    chk("rst_req",  32'(req_out), 0);
    chk("rst_fov",  32'(flit_out_valid), 0);
    chk("rst_drop", 32'(drop_pulse), 0);
    chk("rst_hdr",  32'(hdr_out), 0);
    chk("rst_fout", 32'(flit_out), 0);
    rst = 1'b0;
    tick();

    // 3-flit packet, grant held high
    route_in = r_e; grant_in = 1'b1;
    drive(1'b1, 8'h8D); sb.push_back(8'h8D); tick();
    drive(1'b1, 8'h00); sb.push_back(8'h00); #1;
    chk("t1_hdr", 32'(hdr_out), 32'h8D);
    chk("t1_req_early", 32'(req_out), 0);
    x0 = xfers;
    tick();
    drive(1'b1, 8'h40); sb.push_back(8'h40); #1;
    chk("t1_req", 32'(req_out), 32'(r_e));
    chk("t1_fov0", 32'(flit_out_valid), 1);
    tick();
    drive(1'b0, 8'h00); #1;
    chk("t1_fov1", 32'(flit_out_valid), 1);
    tick(); #1;
    chk("t1_fov2", 32'(flit_out_valid), 1);
    tick(); #1;
    chk("t1_req_idle", 32'(req_out), 0);
    chk("t1_fov_idle", 32'(flit_out_valid), 0);
    chk("t1_state", 32'(dut.state), 32'(IDLE));
    chk("t1_xfers", 32'(xfers - x0), 3);

    // DEPTH=4 fill with grant low; 5th flit must be refused
    grant_in = 1'b0; route_in = r_l;
    drive(1'b1, 8'h81); sb.push_back(8'h81); tick();
    drive(1'b1, 8'h01); sb.push_back(8'h01); #1;
    chk("t2_notfull", 32'(buf_full), 0);
    tick();
    drive(1'b1, 8'h02); sb.push_back(8'h02); tick();
    drive(1'b1, 8'h03); sb.push_back(8'h03); tick();
    drive(1'b1, 8'h42); #1;
    chk("t2_full", 32'(buf_full), 1);
    tick();
    grant_in = 1'b1; #1;
    chk("t2_full_hold", 32'(buf_full), 1);
    chk("t2_pop_when_full", 32'(flit_out_valid), 1);
    tick();
    grant_in = 1'b0; drive(1'b0, 8'h00); #1;
    chk("t2_freed", 32'(buf_full), 0);
    chk("t2_head", 32'(hdr_out), 32'h01);
    drive(1'b1, 8'h41); sb.push_back(8'h41); tick();
    drive(1'b0, 8'h00); grant_in = 1'b1;
    repeat (4) tick();
    chk("t2_req_idle", 32'(req_out), 0);
    chk("t2_empty", 32'(hdr_out), 0);
    grant_in = 1'b0;

    // SINGLE flit
    route_in = r_l; grant_in = 1'b1;
    drive(1'b1, 8'hC5); sb.push_back(8'hC5); tick();
    drive(1'b0, 8'h00); #1;
    chk("t3_hdr", 32'(hdr_out), 32'hC5);
    tick(); #1;
    chk("t3_req", 32'(req_out), 32'(r_l));
    chk("t3_fov", 32'(flit_out_valid), 1);
    chk("t3_fout", 32'(flit_out), 32'hC5);
    tick(); #1;
    chk("t3_req_idle", 32'(req_out), 0);
    chk("t3_fov_idle", 32'(flit_out_valid), 0);
    chk("t3_state", 32'(dut.state), 32'(IDLE));
    chk("t3_route_clr", 32'(dut.route_reg), 0);
    grant_in = 1'b0;

    // Orphan BODY
    route_in = '0;
    drive(1'b1, 8'h05); tick();
    drive(1'b0, 8'h00); #1;
    chk("t4_drop", 32'(drop_pulse), 1);
    chk("t4_req", 32'(req_out), 0);
    chk("t4_hdr", 32'(hdr_out), 32'h05);
    tick(); #1;
    chk("t4_drop_end", 32'(drop_pulse), 0);
    chk("t4_popped", 32'(hdr_out), 0);

    // Unroutable HDR, BODY, TAIL all dropped
    drive(1'b1, 8'h8A); tick();
    drive(1'b1, 8'h0A); #1;
    chk("t5_drop0", 32'(drop_pulse), 1);
    chk("t5_req0", 32'(req_out), 0);
    tick();
    drive(1'b1, 8'h4A); #1;
    chk("t5_drop1", 32'(drop_pulse), 1);
    chk("t5_body", 32'(hdr_out), 32'h0A);
    tick();
    drive(1'b0, 8'h00); #1;
    chk("t5_drop2", 32'(drop_pulse), 1);
    chk("t5_tail", 32'(hdr_out), 32'h4A);
    tick(); #1;
    chk("t5_drop_end", 32'(drop_pulse), 0);
    chk("t5_req_end", 32'(req_out), 0);
    chk("t5_state", 32'(dut.state), 32'(IDLE));

    // Async reset mid-packet
    route_in = 5'b00100; grant_in = 1'b0;
    drive(1'b1, 8'h84); tick();
    drive(1'b1, 8'h04); tick();
    drive(1'b0, 8'h00); #1;
    chk("t6_req", 32'(req_out), 32'h04);
    rst = 1'b1; #1;
    chk("t6_rst_req",  32'(req_out), 0);
    chk("t6_rst_hdr",  32'(hdr_out), 0);
    chk("t6_rst_full", 32'(buf_full), 0);
    chk("t6_rst_fov",  32'(flit_out_valid), 0);
    chk("t6_rst_drop", 32'(drop_pulse), 0);
    tick();
    rst = 1'b0; grant_in = 1'b1; #1;
    chk("t6_state", 32'(dut.state), 32'(IDLE));
    chk("t6_full",  32'(buf_full), 0);
    chk("t6_hdr",   32'(hdr_out), 0);
    tick(); #1;
    chk("t6_no_xfer", 32'(flit_out_valid), 0);
    grant_in = 1'b0;
    tick();

    chk("sb_left", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
